// File: rtl/demux_dispatch_seq.sv
// Upstream sequencer for a 1-to-N demux: accepts one bit per valid/ready handshake and dispatches it
// round-robin or to a fixed destination among those with dest_ready high. Optional: DEMUX_DISPATCH_TIMEOUT_EN.
module demux_dispatch_seq #(
    parameter int N       = 4,
    parameter int LOGN    = $clog2(N),
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_data,
    input  logic            mode,
    input  logic [LOGN-1:0] fixed_sel,
    input  logic [N-1:0]    dest_ready,
    output logic            out_valid,
    output logic [LOGN-1:0] out_s,
    output logic            out_a,
    output logic [LOGN-1:0] ptr
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
   ,output logic            drop_pulse
`endif
);

    // state | meaning
    // IDLE  | no transfer in flight, ready for a bit
    // DRIVE | a bit is on out_s/out_a this cycle; may accept the next one
    // WAIT  | holding a bit that had no eligible destination; upstream stalled
    typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

    if (N < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("demux_dispatch_seq: requires N >= 2 and TIMEOUT >= 1");
    end

    state_t          state, state_nxt;
    logic            hold, hold_nxt;
    logic            valid_nxt, a_nxt;
    logic [LOGN-1:0] s_nxt, ptr_nxt;
    logic            cand_ok;
    logic [LOGN-1:0] cand;
    logic            accept, src_bit;
    int              idx;

    assign in_ready = (state != WAIT);
    assign accept   = in_valid & in_ready;
    assign src_bit  = (state == WAIT) ? hold : in_data;

    // Descending scan so the lowest cyclic offset from ptr wins.
    always_comb begin
        cand_ok = 1'b0;
        cand    = '0;
        idx     = 0;
        if (mode) begin
            if (int'(fixed_sel) < N) begin
                if (dest_ready[fixed_sel]) begin
                    cand_ok = 1'b1;
                    cand    = fixed_sel;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (dest_ready[idx]) begin
                    cand_ok = 1'b1;
                    cand    = LOGN'(idx);
                end
            end
        end
    end

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          drop_nxt;
`endif

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        a_nxt     = 1'b0;
        s_nxt     = out_s;
        ptr_nxt   = ptr;
        hold_nxt  = hold;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        wait_cnt_nxt = '0;
        drop_nxt     = 1'b0;
`endif
        if ((accept || state == WAIT) && cand_ok) begin
            state_nxt = DRIVE;
            valid_nxt = 1'b1;
            s_nxt     = cand;
            a_nxt     = src_bit;
            if (!mode)
                ptr_nxt = (cand == LOGN'(N - 1)) ? '0 : cand + LOGN'(1);
        end else if (accept) begin
            state_nxt = WAIT;
            hold_nxt  = in_data;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
            wait_cnt_nxt = CW'(TIMEOUT - 1);
`endif
        end else if (state == WAIT) begin
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
            // Down-counter reaches zero on the TIMEOUT-th WAIT cycle without a candidate.
            if (wait_cnt == '0) begin
                state_nxt = IDLE;
                drop_nxt  = 1'b1;
            end else begin
                wait_cnt_nxt = wait_cnt - CW'(1);
            end
`endif
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_s     <= '0;
            out_a     <= 1'b0;
            ptr       <= '0;
            hold      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= valid_nxt;
            out_s     <= s_nxt;
            out_a     <= a_nxt;
            ptr       <= ptr_nxt;
            hold      <= hold_nxt;
        end
    end

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            wait_cnt   <= wait_cnt_nxt;
            drop_pulse <= drop_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_demux_dispatch_seq.sv
// Self-checking bench for demux_dispatch_seq: cycle-level behavioural model plus directed vectors.
// Also exercises the drop path when DEMUX_DISPATCH_TIMEOUT_EN is defined.
module tb_demux_dispatch_seq;
    localparam int N       = 4;
    localparam int LOGN    = 2;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_data = 1'b0;
    logic            mode = 1'b0;
    logic [LOGN-1:0] fixed_sel = '0;
    logic [N-1:0]    dest_ready = '0;
    logic            out_valid;
    logic [LOGN-1:0] out_s;
    logic            out_a;
    logic [LOGN-1:0] ptr;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    logic            drop_pulse;
`endif

    int nvec = 0;
    int nfail = 0;

    demux_dispatch_seq #(.N(N), .LOGN(LOGN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .fixed_sel(fixed_sel), .dest_ready(dest_ready),
        .out_valid(out_valid), .out_s(out_s), .out_a(out_a), .ptr(ptr)
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
       ,.drop_pulse(drop_pulse)
`endif
    );

    always #5 clk = ~clk;

    // Model: "waiting" flag with a held bit; destination chosen by smallest cyclic distance from ptr.
    bit m_wait = 0, m_hold = 0, m_valid = 0, m_a = 0, m_drop = 0;
    int m_s = 0, m_ptr = 0, m_wcnt = 0;

    function automatic int pick(input bit md, input int fs, input logic [N-1:0] dr, input int p);
        int best = -1;
        int bd = N;
        if (md) return (fs < N && dr[fs]) ? fs : -1;
        for (int i = 0; i < N; i++)
            if (dr[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_hold = 0; m_valid = 0; m_a = 0; m_drop = 0;
        m_s = 0; m_ptr = 0; m_wcnt = 0;
    endtask

    initial forever begin
        int c;
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else begin
            c = pick(mode, int'(fixed_sel), dest_ready, m_ptr);
            m_valid = 0; m_a = 0; m_drop = 0;
            if (c >= 0 && (m_wait || in_valid)) begin
                m_a = m_wait ? m_hold : in_data;
                m_valid = 1; m_s = c; m_wait = 0;
                if (!mode) m_ptr = (c + 1) % N;
            end else if (m_wait) begin
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
                m_wcnt++;
                if (m_wcnt == TIMEOUT) begin
                    m_wait = 0; m_drop = 1;
                end
`endif
            end else if (in_valid) begin
                m_wait = 1; m_hold = in_data; m_wcnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("m_out_valid", int'(out_valid), int'(m_valid));
        chk("m_out_a", int'(out_a), int'(m_a));
        chk("m_out_s", int'(out_s), m_s);
        chk("m_ptr", int'(ptr), m_ptr);
        chk("m_in_ready", int'(in_ready), int'(!m_wait));
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        chk("m_drop_pulse", int'(drop_pulse), int'(m_drop));
`endif
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input int v, input int s, input int a, input int p, input int r);
        chk({nm, ".valid"}, int'(out_valid), v);
        chk({nm, ".s"}, int'(out_s), s);
        chk({nm, ".a"}, int'(out_a), a);
        chk({nm, ".ptr"}, int'(ptr), p);
        chk({nm, ".ready"}, int'(in_ready), r);
    endtask

    initial begin
        logic [3:0] bits;
        bits = 4'b1101;  // sent LSB first: 1,0,1,1
        step(); step();
        lit("reset", 0, 0, 0, 0, 1);
        rst_n = 1'b1;

        // Round-robin burst across all four destinations
        step();
        dest_ready = 4'b1111; mode = 1'b0;
        in_valid = 1'b1; in_data = bits[0];
        for (int i = 1; i < 4; i++) begin
            step();
            lit("rr_burst", 1, i - 1, int'(bits[i-1]), i % 4, 1);
            in_data = bits[i];
        end
        step();
        lit("rr_last", 1, 3, 1, 0, 1);
        in_valid = 1'b0;
        step();
        lit("rr_idle", 0, 3, 0, 0, 1);

        // Move ptr to 2, then wrap past 3 to destination 0
        dest_ready = 4'b0010; in_valid = 1'b1; in_data = 1'b0;
        step();
        lit("set_ptr", 1, 1, 0, 2, 1);
        dest_ready = 4'b0011; in_data = 1'b1;
        step();
        lit("wrap", 1, 0, 1, 1, 1);
        in_valid = 1'b0;
        step();

        // Nothing ready: stall in WAIT; in_valid with data 0 must be ignored
        dest_ready = 4'b0000; in_valid = 1'b1; in_data = 1'b1;
        step();
        lit("wait_enter", 0, 0, 0, 1, 0);
        in_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            lit("wait_hold", 0, 0, 0, 1, 0);
        end
        dest_ready = 4'b1000;
        step();
        lit("wait_release", 1, 3, 1, 0, 1);
        in_valid = 1'b0;
        step();
        lit("wait_idle", 0, 3, 0, 0, 1);

        // Fixed mode: direct dispatch keeps ptr, then blocked fixed_sel rescued by round-robin
        mode = 1'b1; fixed_sel = 2'd3; dest_ready = 4'b1000;
        in_valid = 1'b1; in_data = 1'b0;
        step();
        lit("fixed_hit", 1, 3, 0, 0, 1);
        fixed_sel = 2'd2; dest_ready = 4'b1011; in_data = 1'b1;
        step();
        lit("fixed_block", 0, 3, 0, 0, 0);
        in_valid = 1'b0; mode = 1'b0; dest_ready = 4'b0001;
        step();
        lit("mode_switch", 1, 0, 1, 1, 1);
        step();

        // Async reset while in WAIT
        dest_ready = 4'b0000; in_valid = 1'b1; in_data = 1'b1;
        step();
        in_valid = 1'b0;
        lit("pre_rst_wait", 0, 0, 0, 1, 0);
        #1 rst_n = 1'b0;
        #1 lit("rst_in_wait", 0, 0, 0, 0, 1);
        step();
        rst_n = 1'b1;
        step();

        // Async reset during DRIVE
        dest_ready = 4'b0100; in_valid = 1'b1; in_data = 1'b1;
        step();
        in_valid = 1'b0;
        lit("pre_rst_drive", 1, 2, 1, 3, 1);
        #1 rst_n = 1'b0;
        #1 lit("rst_in_drive", 0, 0, 0, 0, 1);
        step();
        rst_n = 1'b1;
        step();
        lit("post_rst", 0, 0, 0, 0, 1);

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        begin
            int n_waited = 0;
            bit seen = 0;
            dest_ready = 4'b0000; in_valid = 1'b1; in_data = 1'b1;
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 3 * TIMEOUT && !seen; i++) begin
                step();
                n_waited++;
                if (drop_pulse) seen = 1;
                chk("to_no_valid", int'(out_valid), 0);
            end
            chk("to_seen", int'(seen), 1);
            chk("to_cycles", n_waited, TIMEOUT);
            step();
            chk("to_pulse_once", int'(drop_pulse), 0);
            chk("to_idle_ready", int'(in_ready), 1);
        end
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
